// File: rtl/spectrum_pkg.sv
// Shared types, defaults and helpers for the spectrum bar renderer and its peak-hold bank.
package spectrum_pkg;

    localparam int MAG_WIDTH_DEF = 23;
    localparam int N_BINS_DEF    = 16;
    localparam int X_WIDTH_DEF   = 10;
    localparam int MAG_SHIFT_DEF = 13;
    localparam int ROW_SHIFT_DEF = 3;
    localparam int Y_OFFSET_DEF  = 0;
    localparam int DECAY_DEF     = 1;
    localparam int BIN_W         = $clog2(N_BINS_DEF);

    // Working width of the saturating helpers; wide enough for any pixel coordinate.
    localparam int SAT_W = 32;

    typedef enum logic {
        IDLE = 1'b0,
        COPY = 1'b1
    } copy_state_t;

    function automatic logic [SAT_W-1:0] sat_sub(input logic [SAT_W-1:0] a,
                                                 input logic [SAT_W-1:0] b);
        return (a > b) ? (a - b) : '0;
    endfunction

endpackage

// File: rtl/peak_hold_bank.sv
// Per-bin displayed bar length and decaying peak marker, updated one bin per cycle
// during a copy and read combinationally by the raster row.
module peak_hold_bank
    import spectrum_pkg::*;
#(
    parameter int N_BINS  = N_BINS_DEF,
    parameter int X_WIDTH = X_WIDTH_DEF,
    parameter int DECAY   = DECAY_DEF
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       copy_en,
    input  logic [$clog2(N_BINS)-1:0]  copy_idx,
    input  logic [X_WIDTH-1:0]         copy_len,
    input  logic [$clog2(N_BINS)-1:0]  rd_row,
    output logic [X_WIDTH-1:0]         rd_disp,
    output logic [X_WIDTH-1:0]         rd_peak
);

    localparam int IDX_W = $clog2(N_BINS);

    logic [X_WIDTH-1:0] disp_reg [N_BINS];
    logic [X_WIDTH-1:0] peak_reg [N_BINS];

    genvar gi;
    generate
        for (gi = 0; gi < N_BINS; gi++) begin : g_bin
            logic               hit;
            logic [X_WIDTH-1:0] decayed;
            logic [X_WIDTH-1:0] peak_next;

            assign hit       = copy_en && (copy_idx == IDX_W'(gi));
            assign decayed   = X_WIDTH'(sat_sub(SAT_W'(peak_reg[gi]), SAT_W'(DECAY)));
            // A fresh bar longer than the decayed marker pushes the marker up.
            assign peak_next = (copy_len > decayed) ? copy_len : decayed;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    disp_reg[gi] <= '0;
                    peak_reg[gi] <= '0;
                end else if (hit) begin
                    disp_reg[gi] <= copy_len;
                    peak_reg[gi] <= peak_next;
                end
            end
        end
    endgenerate

    assign rd_disp = disp_reg[rd_row];
    assign rd_peak = peak_reg[rd_row];

endmodule

// File: rtl/spectrum_bar_renderer.sv
// Double-buffered N-bin bar graph: shadow bins from the sdft are copied into the
// display/peak bank on each frame edge and drawn as horizontal bars on the raster.
module spectrum_bar_renderer
    import spectrum_pkg::*;
#(
    parameter int MAG_WIDTH = MAG_WIDTH_DEF,
    parameter int N_BINS    = N_BINS_DEF,
    parameter int X_WIDTH   = X_WIDTH_DEF,
    parameter int MAG_SHIFT = MAG_SHIFT_DEF,
    parameter int ROW_SHIFT = ROW_SHIFT_DEF,
    parameter int Y_OFFSET  = Y_OFFSET_DEF,
    parameter int DECAY     = DECAY_DEF
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       bin_valid,
    input  logic [$clog2(N_BINS)-1:0]  bin_index,
    input  logic [MAG_WIDTH-1:0]       bin_mag,
    output logic                       bin_ready,
    input  logic                       frame_strobe,
    input  logic [X_WIDTH-1:0]         x_px,
    input  logic [X_WIDTH-1:0]         y_px,
    input  logic                       activevideo,
    output logic                       r,
    output logic                       g,
    output logic                       b,
    output logic                       frame_overrun
);

    localparam int IDX_W = $clog2(N_BINS);
    localparam logic [X_WIDTH-1:0] LEN_MAX = '1;

    // ---------------- shadow buffer ----------------
    logic [MAG_WIDTH-1:0] shadow_reg [N_BINS];

    genvar gi;
    generate
        for (gi = 0; gi < N_BINS; gi++) begin : g_shadow
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    shadow_reg[gi] <= '0;
                end else if (bin_valid && bin_ready && (bin_index == IDX_W'(gi))) begin
                    shadow_reg[gi] <= bin_mag;
                end
            end
        end
    endgenerate

    // ---------------- copy FSM ----------------
    copy_state_t        state_reg, state_next;
    logic [IDX_W-1:0]   idx_reg, idx_next;
    logic               overrun_reg, overrun_next;
    logic               strobe_reg;
    logic               rise;
    logic               copy_en;

    assign rise = frame_strobe && !strobe_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= IDLE;
            idx_reg     <= '0;
            overrun_reg <= 1'b0;
            strobe_reg  <= 1'b0;
        end else begin
            state_reg   <= state_next;
            idx_reg     <= idx_next;
            overrun_reg <= overrun_next;
            strobe_reg  <= frame_strobe;
        end
    end

    always_comb begin
        state_next   = state_reg;
        idx_next     = idx_reg;
        overrun_next = overrun_reg;
        bin_ready    = 1'b0;
        copy_en      = 1'b0;
        case (state_reg)
            IDLE: begin
                bin_ready = 1'b1;
                if (rise) begin
                    state_next = COPY;
                    idx_next   = '0;
                end
            end
            COPY: begin
                copy_en  = 1'b1;
                idx_next = idx_reg + 1'b1;
                // A second edge mid-copy is only flagged; the running copy finishes.
                if (rise) begin
                    overrun_next = 1'b1;
                end
                if (idx_reg == IDX_W'(N_BINS - 1)) begin
                    state_next = IDLE;
                    idx_next   = '0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign frame_overrun = overrun_reg;

    // Bar length in pixels, clamped so large magnitudes never wrap.
    logic [MAG_WIDTH-1:0] len_wide;
    logic [X_WIDTH-1:0]   copy_len;

    assign len_wide = shadow_reg[idx_reg] >> MAG_SHIFT;
    assign copy_len = (len_wide > MAG_WIDTH'(LEN_MAX)) ? LEN_MAX : len_wide[X_WIDTH-1:0];

    // ---------------- display / peak bank ----------------
    logic [IDX_W-1:0]   rd_row;
    logic [X_WIDTH-1:0] rd_disp;
    logic [X_WIDTH-1:0] rd_peak;

    peak_hold_bank #(
        .N_BINS  (N_BINS),
        .X_WIDTH (X_WIDTH),
        .DECAY   (DECAY)
    ) u_bank (
        .clk      (clk),
        .reset_n  (reset_n),
        .copy_en  (copy_en),
        .copy_idx (idx_reg),
        .copy_len (copy_len),
        .rd_row   (rd_row),
        .rd_disp  (rd_disp),
        .rd_peak  (rd_peak)
    );

    // ---------------- pixel decode ----------------
    logic [X_WIDTH:0]   yrel_ext;
    logic [X_WIDTH-1:0] yrel;
    logic [X_WIDTH-1:0] row_full;
    logic [X_WIDTH-1:0] row_hi;
    logic               in_band;
    logic               bar_on;
    logic               peak_on;

    // The extra top bit borrows when y_px is above the first bar line.
    assign yrel_ext = {1'b0, y_px} - (X_WIDTH + 1)'(Y_OFFSET);
    assign yrel     = yrel_ext[X_WIDTH-1:0];
    assign row_full = yrel >> ROW_SHIFT;
    assign row_hi   = row_full >> IDX_W;
    assign rd_row   = row_full[IDX_W-1:0];

    assign in_band = activevideo && !yrel_ext[X_WIDTH] && (row_hi == '0)
                     && !(&yrel[ROW_SHIFT-1:0]);
    assign bar_on  = in_band && (x_px < rd_disp);
    assign peak_on = in_band && (rd_peak != '0) && (x_px == rd_peak);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r <= 1'b0;
            g <= 1'b0;
            b <= 1'b0;
        end else begin
            r <= peak_on;
            g <= bar_on && !peak_on;
            b <= bar_on;
        end
    end

endmodule

// File: tb/tb_spectrum_bar_renderer.sv
// Self-checking bench for spectrum_bar_renderer: table-driven pixel vectors, a
// pixel scoreboard queue and hand-written sequences for the copy corner cases.
module tb_spectrum_bar_renderer;
    import spectrum_pkg::*;

    localparam int NB = 16;
    localparam int XW = 10;
    localparam int MS = 13;
    localparam int RS = 3;
    localparam int YO = 0;
    localparam int DC = 1;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             bin_valid = 1'b0;
    logic [BIN_W-1:0] bin_index = '0;
    logic [22:0]      bin_mag = '0;
    logic             bin_ready;
    logic             frame_strobe = 1'b0;
    logic [XW-1:0]    x_px = '0;
    logic [XW-1:0]    y_px = '0;
    logic             activevideo = 1'b0;
    logic             r, g, b;
    logic             frame_overrun;

    spectrum_bar_renderer dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .bin_valid     (bin_valid),
        .bin_index     (bin_index),
        .bin_mag       (bin_mag),
        .bin_ready     (bin_ready),
        .frame_strobe  (frame_strobe),
        .x_px          (x_px),
        .y_px          (y_px),
        .activevideo   (activevideo),
        .r             (r),
        .g             (g),
        .b             (b),
        .frame_overrun (frame_overrun)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model of shadow, displayed length and peak per bin.
    int ms [NB];
    int md [NB];
    int mp [NB];

    typedef struct packed {
        logic [63:0] nm;
        logic [2:0]  rgb;
    } sb_t;
    sb_t sb_q[$];

    typedef struct packed {
        logic [63:0] nm;
        logic [9:0]  x;
        logic [9:0]  y;
        logic        av;
        logic [2:0]  rgb;
    } vec_t;
    vec_t tbl [12];

    task automatic check(input logic [63:0] nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    function automatic logic [2:0] model_rgb(input int x, input int y, input bit av);
        int  yrel, row;
        bit  bar, pk;
        yrel = y - YO;
        row  = yrel >>> RS;
        if (!av || yrel < 0 || row >= NB || (yrel % (1 << RS)) == (1 << RS) - 1)
            return 3'b000;
        bar = (x < md[row]);
        pk  = (mp[row] != 0) && (x == mp[row]);
        return {pk, bar && !pk, bar};
    endfunction

    function automatic void model_copy();
        int len, dec;
        for (int i = 0; i < NB; i++) begin
            len = ms[i] >>> MS;
            if (len > (1 << XW) - 1) len = (1 << XW) - 1;
            dec = (mp[i] > DC) ? mp[i] - DC : 0;
            mp[i] = (len > dec) ? len : dec;
            md[i] = len;
        end
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < NB; i++) begin
            ms[i] = 0;
            md[i] = 0;
            mp[i] = 0;
        end
    endfunction

    // Drive one pixel, queue its expectation, compare one clock later.
    task automatic pix(input logic [63:0] nm, input int x, input int y, input bit av,
                       input logic [2:0] exp);
        sb_t e;
        int  xv, yv;
        xv = x;
        yv = y;
        @(negedge clk);
        x_px        = xv[XW-1:0];
        y_px        = yv[XW-1:0];
        activevideo = av;
        sb_q.push_back({nm, exp});
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        total++;
        if ({r, g, b} !== e.rgb) begin
            bad++;
            $display("FAIL %s: rgb got %b want %b (x=%0d y=%0d)", e.nm, {r, g, b}, e.rgb, xv, yv);
        end else begin
            $display("pix %s x=%0d y=%0d rgb=%b", e.nm, xv, yv, e.rgb);
        end
    endtask

    task automatic pixm(input logic [63:0] nm, input int x, input int y);
        pix(nm, x, y, 1'b1, model_rgb(x, y, 1'b1));
    endtask

    task automatic wr(input int idx, input int mag);
        @(negedge clk);
        bin_valid = 1'b1;
        bin_index = idx[BIN_W-1:0];
        bin_mag   = mag[22:0];
        @(negedge clk);
        bin_valid = 1'b0;
        ms[idx]   = mag;
        $display("write bin=%0d mag=0x%06h", idx, mag);
    endtask

    // Vsync-like level held a few cycles; counts cycles with bin_ready low.
    task automatic frame(input logic [63:0] nm);
        int cnt;
        cnt = 0;
        @(negedge clk);
        frame_strobe = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 100; k++) begin
            if (k == 2) frame_strobe = 1'b0;
            if (bin_ready) break;
            cnt++;
            @(negedge clk);
        end
        frame_strobe = 1'b0;
        check(nm, cnt, NB);
        model_copy();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        model_clear();

        tbl[0]  = {64'("t2_a"), 10'd0,    10'd24, 1'b1, 3'b011};
        tbl[1]  = {64'("t2_b"), 10'd4,    10'd30, 1'b1, 3'b011};
        tbl[2]  = {64'("t2_pk0"), 10'd5,  10'd24, 1'b1, 3'b100};
        tbl[3]  = {64'("t2_pk1"), 10'd5,  10'd30, 1'b1, 3'b100};
        tbl[4]  = {64'("t2_past"), 10'd6, 10'd24, 1'b1, 3'b000};
        tbl[5]  = {64'("t2_gap0"), 10'd0, 10'd31, 1'b1, 3'b000};
        tbl[6]  = {64'("t2_gap5"), 10'd5, 10'd31, 1'b1, 3'b000};
        tbl[7]  = {64'("t2_noav"), 10'd0, 10'd24, 1'b0, 3'b000};
        tbl[8]  = {64'("t2_row2"), 10'd0, 10'd16, 1'b1, 3'b000};
        tbl[9]  = {64'("t2_row4"), 10'd0, 10'd32, 1'b1, 3'b000};
        tbl[10] = {64'("t2_mid"), 10'd3,  10'd27, 1'b1, 3'b011};
        tbl[11] = {64'("t2_far"), 10'd1023, 10'd24, 1'b1, 3'b000};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_rdy", int'(bin_ready), 1);
        check("rst_rgb", int'({r, g, b}), 0);
        check("rst_ovr", int'(frame_overrun), 0);
        reset_n = 1'b1;

        // Single bar, 8-line band with gap, 1-clock render latency
        wr(3, 'h00A000);
        frame("t2_busy");
        for (int i = 0; i < 12; i++)
            pix(tbl[i].nm, int'(tbl[i].x), int'(tbl[i].y), tbl[i].av, tbl[i].rgb);

        // Peak decay down to disappearance
        wr(0, 100 << MS);
        frame("t3_f1");
        pix("t3_bar", 99, 0, 1'b1, 3'b011);
        pix("t3_pk", 100, 0, 1'b1, 3'b100);
        wr(0, 0);
        for (int k = 0; k < 3; k++) begin
            frame("t3_fz");
            pix("t3_dec", 99 - k, 0, 1'b1, 3'b100);
            pix("t3_emp", 0, 0, 1'b1, 3'b000);
        end
        for (int k = 0; k < 97; k++) begin
            frame("t3_fz");
            pixm("t3_trk", mp[0], 0);
        end
        pix("t3_gone0", 0, 0, 1'b1, 3'b000);
        pix("t3_gone1", 1, 0, 1'b1, 3'b000);

        // Saturation
        wr(5, 'h7FFFFF);
        frame("t4_busy");
        pix("t4_x0", 0, 40, 1'b1, 3'b011);
        pix("t4_x1022", 1022, 40, 1'b1, 3'b011);
        pix("t4_x1023", 1023, 40, 1'b1, 3'b100);
        pix("t4_gap", 500, 47, 1'b1, 3'b000);

        // Write on the same cycle as the edge; write during copy dropped
        @(negedge clk);
        bin_valid    = 1'b1;
        bin_index    = '0;
        bin_mag      = 23'h004000;
        frame_strobe = 1'b1;
        ms[0]        = 'h004000;
        @(negedge clk);
        bin_valid = 1'b0;
        cnt = 0;
        for (int k = 0; k < 100; k++) begin
            if (k == 1) begin
                bin_index = 1;
                bin_mag   = 23'h7FFFFF;
                bin_valid = 1'b1;
            end
            if (k == 2) bin_valid = 1'b0;
            if (k == 3) frame_strobe = 1'b0;
            if (bin_ready) break;
            cnt++;
            @(negedge clk);
        end
        bin_valid    = 1'b0;
        frame_strobe = 1'b0;
        check("t6_busy", cnt, NB);
        model_copy();
        pix("t6_bar", 1, 0, 1'b1, 3'b011);
        pix("t6_pk", 2, 0, 1'b1, 3'b100);
        frame("t6_f2");
        pix("t6_drop", 0, 8, 1'b1, 3'b000);

        // Overrun: second edge four cycles into the copy
        check("t5_pre", int'(frame_overrun), 0);
        wr(9, 'h060000);
        @(negedge clk);
        frame_strobe = 1'b1;
        @(negedge clk);
        cnt = 0;
        for (int k = 0; k < 100; k++) begin
            if (k == 0) frame_strobe = 1'b0;
            if (k == 4) frame_strobe = 1'b1;
            if (k == 6) frame_strobe = 1'b0;
            if (bin_ready) break;
            cnt++;
            @(negedge clk);
        end
        frame_strobe = 1'b0;
        check("t5_busy", cnt, NB);
        check("t5_ovr", int'(frame_overrun), 1);
        model_copy();
        pixm("t5_bar", 47, 72);
        pixm("t5_pk", 48, 72);
        wr(9, 'h010000);
        frame("t5_next");
        check("t5_stick", int'(frame_overrun), 1);
        pix("t5_b7", 7, 72, 1'b1, 3'b011);
        pix("t5_b8", 8, 72, 1'b1, 3'b000);
        pix("t5_pk47", 47, 72, 1'b1, 3'b100);

        // Reset in the middle of a copy
        pix("t1_pre", 0, 0, 1'b1, 3'b011);
        wr(7, 'h020000);
        @(negedge clk);
        frame_strobe = 1'b1;
        @(negedge clk);
        frame_strobe = 1'b0;
        repeat (5) @(negedge clk);
        check("t1_busy", int'(bin_ready), 0);
        reset_n = 1'b0;
        #1;
        check("t1_rgb", int'({r, g, b}), 0);
        check("t1_rdy", int'(bin_ready), 1);
        check("t1_ovr", int'(frame_overrun), 0);
        model_clear();
        @(negedge clk);
        reset_n = 1'b1;
        frame("t1_frm");
        pix("t1_b0", 0, 0, 1'b1, 3'b000);
        pix("t1_b3", 0, 24, 1'b1, 3'b000);
        pix("t1_b7", 0, 56, 1'b1, 3'b000);
        pix("t1_b9", 0, 72, 1'b1, 3'b000);
        check("t1_ovr2", int'(frame_overrun), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
